// File: rtl/zeroriscy_irq_arbiter.sv
// External interrupt arbiter for the zero-riscy core: edge-captures event lines into a pending
// register, masks them and holds a fixed-priority (lowest id wins) request until the core acks it.
module zeroriscy_irq_arbiter #(
    parameter int          NUM_IRQ    = 32,
    parameter logic [31:0] RESET_MASK = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] event_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    output logic [NUM_IRQ-1:0] mask_o,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i,
    output logic               ack_err_o,
    input  logic               ack_err_clr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         id_q, id_d;
    logic [NUM_IRQ-1:0] event_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               ack_err_q, ack_err_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] clr;
    logic               any;
    logic [4:0]         sel;
    logic               ack_ok;

    assign rise   = event_i & ~event_q;
    assign active = pending_q & mask_q;
    assign any    = |active;

    // Scan from the top so the last hit, i.e. the lowest index, wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) sel = 5'(i);
        end
    end

    // id_q is always < NUM_IRQ, so an out-of-range ack id can never match.
    always_comb begin
        ack_ok = irq_ack_i && (state_q == REQ) && (irq_ack_id_i == id_q);
        clr    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = ack_ok && (id_q == 5'(i));
        end
    end

    always_comb begin
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we_i ? mask_wdata_i : mask_q;
        ack_err_d = ack_err_clr_i ? 1'b0 : ack_err_q;
        if (irq_ack_i && !ack_ok) ack_err_d = 1'b1;
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // FSM: next state. id_q stays frozen outside IDLE so the acked id matches the presented one.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: if (any) begin
                state_d = REQ;
                id_d    = sel;
            end
            REQ:  if (ack_ok) state_d = GAP;
            GAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        irq_o    = (state_q == REQ);
        irq_id_o = id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q   <= '0;
            pending_q <= '0;
            mask_q    <= RESET_MASK[NUM_IRQ-1:0];
            ack_err_q <= 1'b0;
        end else begin
            event_q   <= event_i;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign mask_o    = mask_q;
    assign pending_o = pending_q;
    assign ack_err_o = ack_err_q;

endmodule
